// File: rtl/spi_slave_endpoint.sv
// rtl/spi_slave_endpoint.sv - mode-0 SPI slave: oversampled pins, 32-bit rx deserialiser, preloaded tx serialiser.
// Optional partial-frame / reset-release error pulse: define SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_endpoint #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              SS_n,
  output logic              MISO,
  input  logic [DATA_W-1:0] TxData,
  input  logic              TxLoad,
  output logic              TxEmpty,
  output logic [DATA_W-1:0] RxData,
  output logic              RxValid,
  output logic              Busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic              FrameErr
`endif
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic                   r_sclk_prev;
  logic                   r_ss_prev;
  logic [CNT_W-1:0]       r_bitcnt;
  logic [DATA_W-2:0]      r_rx_sh;
  logic [DATA_W-1:0]      r_tx_sh;
  logic [DATA_W-1:0]      r_tx_buf;
  logic                   r_tx_empty;
  logic [DATA_W-1:0]      r_rx_data;
  logic                   r_rx_valid;
  logic                   r_miso;

  logic                   w_sclk_s, w_mosi_s, w_ss_s;
  logic                   w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
  logic                   w_start, w_abort, w_bit, w_last, w_shift, w_xfer;
  logic [DATA_W-1:0]      w_tx_next;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
  assign w_ss_rise   = w_ss_s & ~r_ss_prev;
  assign w_ss_fall   = ~w_ss_s & r_ss_prev;

  // An empty buffer sends zeros, unless a load lands in the very cycle of the transfer.
  assign w_tx_next = r_tx_empty ? (TxLoad ? TxData : '0) : r_tx_buf;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '1;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
      r_sclk_prev <= w_sclk_s;
      r_ss_prev   <= w_ss_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // SS_n rise wins over any SCLK edge seen in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_bit       = 1'b0;
    w_last      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt = ACTIVE;
          w_start     = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_ss_rise) begin
          w_state_nxt = IDLE;
          w_abort     = 1'b1;
        end else if (w_sclk_rise) begin
          w_bit  = 1'b1;
          w_last = (r_bitcnt == LAST_BIT);
        end else if (w_sclk_fall && (r_bitcnt != '0)) begin
          w_shift = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_xfer = w_start | w_last;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bitcnt   <= '0;
      r_rx_sh    <= '0;
      r_tx_sh    <= '0;
      r_tx_buf   <= '0;
      r_tx_empty <= 1'b1;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_xfer) begin
        r_tx_sh    <= w_tx_next;
        r_miso     <= w_tx_next[DATA_W-1];
        r_tx_empty <= 1'b1;
      end else begin
        if (TxLoad && r_tx_empty) begin
          r_tx_buf   <= TxData;
          r_tx_empty <= 1'b0;
        end
        if (w_shift) begin
          r_tx_sh <= r_tx_sh << 1;
          r_miso  <= r_tx_sh[DATA_W-2];
        end
        if (w_abort) r_miso <= 1'b0;
      end
      if (w_start) begin
        r_bitcnt <= '0;
        r_rx_sh  <= '0;
      end
      if (w_bit) begin
        r_rx_sh  <= {r_rx_sh[DATA_W-3:0], w_mosi_s};
        r_bitcnt <= w_last ? '0 : r_bitcnt + 1'b1;
      end
      if (w_last) begin
        r_rx_data  <= {r_rx_sh, w_mosi_s};
        r_rx_valid <= 1'b1;
      end
      if (w_abort) begin
        r_rx_sh  <= '0;
        r_bitcnt <= '0;
      end
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  localparam int REL_W = $clog2(SYNC_STAGES + 1);

  logic [REL_W-1:0] r_rel_cnt;
  logic             r_rel_armed;
  logic             r_frame_err;

  // After reset the synchroniser needs SYNC_STAGES edges before SS_n_sync reflects the pin.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rel_cnt   <= REL_W'(SYNC_STAGES);
      r_rel_armed <= 1'b1;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_abort && (r_bitcnt != '0);
      if (r_rel_cnt != '0) begin
        r_rel_cnt <= r_rel_cnt - 1'b1;
      end else if (r_rel_armed) begin
        r_rel_armed <= 1'b0;
        if (!w_ss_s) r_frame_err <= 1'b1;
      end
    end
  end

  assign FrameErr = r_frame_err;
`endif

  assign MISO    = r_miso;
  assign TxEmpty = r_tx_empty;
  assign RxData  = r_rx_data;
  assign RxValid = r_rx_valid;
  assign Busy    = (r_state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_endpoint.sv
// tb/tb_spi_slave_endpoint.sv - directed bench for spi_slave_endpoint with a mode-0 master at clk/8.
module tb_spi_slave_endpoint;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        SS_n = 1'b1;
  logic        MISO;
  logic [31:0] TxData = '0;
  logic        TxLoad = 1'b0;
  logic        TxEmpty;
  logic [31:0] RxData;
  logic        RxValid;
  logic        Busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic        FrameErr;
  int          fe_cnt = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int rv_cnt   = 0;
  int rv_wide  = 0;
  logic rv_prev = 1'b0;

  spi_slave_endpoint #(.DATA_W(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n), .MISO(MISO),
    .TxData(TxData), .TxLoad(TxLoad), .TxEmpty(TxEmpty),
    .RxData(RxData), .RxValid(RxValid), .Busy(Busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , .FrameErr(FrameErr)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (RxValid) rv_cnt++;
    if (RxValid && rv_prev) rv_wide++;
    rv_prev = RxValid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    if (FrameErr) fe_cnt++;
`endif
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tx_load(input logic [31:0] v);
    TxData = v;
    TxLoad = 1'b1;
    tick(1);
    TxLoad = 1'b0;
  endtask

  // Master drives MOSI with SCLK low and samples MISO at the rising edge.
  task automatic spi_bits(input logic [31:0] w, input int nbits, output logic [31:0] m);
    m = '0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = w[31-i];
      tick(4);
      SCLK = 1'b1;
      m = {m[30:0], MISO};
      tick(4);
      SCLK = 1'b0;
    end
  endtask

  task automatic ss_begin();
    SS_n = 1'b0;
    tick(8);
  endtask

  task automatic ss_end();
    tick(8);
    SS_n = 1'b1;
    tick(8);
  endtask

  logic [31:0] m0, m1;
  int rv0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  int fe0;
`endif

  initial begin
    tick(3);
    check_eq("rst_miso", MISO, 0);
    check_eq("rst_rxdata", RxData, 0);
    check_eq("rst_rxvalid", RxValid, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_txempty", TxEmpty, 1);
    rstn = 1'b1;
    tick(4);

    // single frame
    tx_load(32'hDEADBEEF);
    check_eq("load_txempty", TxEmpty, 0);
    rv0 = rv_cnt;
    ss_begin();
    check_eq("single_busy", Busy, 1);
    check_eq("single_txempty", TxEmpty, 1);
    spi_bits(32'hA5A51234, 32, m0);
    ss_end();
    check_eq("single_rxdata", RxData, 32'hA5A51234);
    check_eq("single_rvcnt", rv_cnt - rv0, 1);
    check_eq("single_miso", m0, 32'hDEADBEEF);
    check_eq("single_busy_end", Busy, 0);

    // back-to-back frames with SS_n held low
    tx_load(32'h11111111);
    rv0 = rv_cnt;
    ss_begin();
    tx_load(32'h22222222);
    spi_bits(32'h0000FFFF, 32, m0);
    check_eq("b2b_rx0", RxData, 32'h0000FFFF);
    spi_bits(32'hFFFF0000, 32, m1);
    ss_end();
    check_eq("b2b_rx1", RxData, 32'hFFFF0000);
    check_eq("b2b_rvcnt", rv_cnt - rv0, 2);
    check_eq("b2b_miso0", m0, 32'h11111111);
    check_eq("b2b_miso1", m1, 32'h22222222);

    // empty transmit buffer
    ss_begin();
    spi_bits(32'h12345678, 32, m0);
    ss_end();
    check_eq("empty_miso", m0, 0);
    check_eq("empty_rxdata", RxData, 32'h12345678);

    // abort after 12 bits
    rv0 = rv_cnt;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    fe0 = fe_cnt;
`endif
    ss_begin();
    spi_bits(32'hFFFFFFFF, 12, m0);
    ss_end();
    check_eq("abort_rvcnt", rv_cnt - rv0, 0);
    check_eq("abort_rxdata", RxData, 32'h12345678);
    check_eq("abort_busy", Busy, 0);
    check_eq("abort_miso", MISO, 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check_eq("abort_frameerr", fe_cnt - fe0, 1);
`endif
    ss_begin();
    spi_bits(32'hCAFEF00D, 32, m0);
    ss_end();
    check_eq("after_abort_rx", RxData, 32'hCAFEF00D);
    check_eq("after_abort_rvcnt", rv_cnt - rv0, 1);

    // reset mid-frame
    tx_load(32'h89ABCDEF);
    rv0 = rv_cnt;
    ss_begin();
    spi_bits(32'h00000000, 20, m0);
    rstn = 1'b0;
    tick(2);
    check_eq("midrst_miso", MISO, 0);
    check_eq("midrst_rxdata", RxData, 0);
    check_eq("midrst_rxvalid", RxValid, 0);
    check_eq("midrst_busy", Busy, 0);
    check_eq("midrst_txempty", TxEmpty, 1);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    fe0 = fe_cnt;
`endif
    rstn = 1'b1;
    tick(8);
    SS_n = 1'b1;
    tick(8);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check_eq("release_frameerr", fe_cnt - fe0, 1);
`endif
    check_eq("midrst_rvcnt", rv_cnt - rv0, 0);
    ss_begin();
    spi_bits(32'h0F0F0F0F, 32, m0);
    ss_end();
    check_eq("after_rst_rx", RxData, 32'h0F0F0F0F);
    check_eq("after_rst_miso", m0, 0);

    // TxLoad coincides with the synchronised SS_n fall
    SS_n = 1'b0;
    tick(2);
    tx_load(32'h55AA55AA);
    check_eq("coll_txempty", TxEmpty, 1);
    tick(6);
    spi_bits(32'h00000001, 32, m0);
    ss_end();
    check_eq("coll_miso", m0, 32'h55AA55AA);
    check_eq("coll_txempty_end", TxEmpty, 1);
    check_eq("coll_rx", RxData, 32'h00000001);
    check_eq("rv_pulse_width", rv_wide, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
